// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, round constants and helpers for the Ascon permutation engine
//
// Contents:
//   ascon_state_t : 320-bit state as five 64-bit lanes, x0 = word [0] ... x4 = word [4]
//   rnd_t         : 4-bit global round index (0..15) into ASCON_RC
//   ASCON_RC      : round constants for the 16-round schedule; p[nr] uses the last nr entries
//   ascon_fsm_e   : engine FSM encoding (IDLE/RUN/DONE)
//   ror64         : 64-bit rotate right
package ascon_pkg;

    typedef logic [4:0][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ascon_fsm_e;

    localparam logic [7:0] ASCON_RC [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_permutation_engine_round.sv
// rtl/ascon_permutation_engine_round.sv - one combinational Ascon round (constant, S-box, linear layer)
//
// Ports:
//   rnd_i         in   rnd_t          global round index selecting ASCON_RC
//   state_array_i in   ascon_state_t  state before the round
//   state_array_o out  ascon_state_t  state after the round
module ascon_round
    import ascon_pkg::*;
(
    input  rnd_t         rnd_i,
    input  ascon_state_t state_array_i,
    output ascon_state_t state_array_o
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = state_array_i[0];
        x1 = state_array_i[1];
        x2 = state_array_i[2] ^ {56'h0, ASCON_RC[rnd_i]};
        x3 = state_array_i[3];
        x4 = state_array_i[4];

        // Bitsliced form of the 5-bit S-box, x0 being the MSB of each slice.
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_array_o[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        state_array_o[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        state_array_o[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        state_array_o[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        state_array_o[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    end

endmodule

// File: rtl/ascon_permutation_engine.sv
// rtl/ascon_permutation_engine.sv - iterative Ascon-p[nr] engine, UNROLL rounds per clock
//
// Ports:
//   clk_i         in   1    clock, rising edge
//   rst_ni        in   1    asynchronous active-low reset
//   in_valid_i    in   1    request valid
//   in_ready_o    out  1    engine idle and able to accept
//   nr_i          in   5    round count, legal 1..16 and a multiple of UNROLL
//   state_array_i in   320  input state
//   out_valid_o   out  1    result valid
//   out_ready_i   in   1    consumer accepts result
//   state_array_o out  320  result (state register)
//   err_o         out  1    with out_valid_o: request had an illegal nr_i
//   busy_o        out  1    FSM not idle
module ascon_permutation_engine
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [4:0]   nr_i,
    input  ascon_state_t state_array_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_array_o,
    output logic         err_o,
    output logic         busy_o
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("ascon_permutation_engine: UNROLL must be 1, 2 or 4");
    end

    localparam logic [4:0] UNROLL_STEP = 5'(UNROLL);
    localparam logic [4:0] UNROLL_MASK = 5'(UNROLL - 1);

    ascon_fsm_e   fsm_q;
    ascon_state_t state_q;
    logic [4:0]   nr_q;
    logic [4:0]   cnt_q;
    logic         out_valid_q;
    logic         err_q;

    logic         accept;
    logic         nr_legal;
    ascon_state_t round_state_d;
    ascon_state_t chain [UNROLL+1];

    assign accept   = in_valid_i && (fsm_q == IDLE);
    assign nr_legal = (nr_i != 5'd0) && (nr_i <= 5'd16) && ((nr_i & UNROLL_MASK) == 5'd0);

    // Round chain: stage u works on global round 16 - nr + cnt + u, so a
    // shorter permutation runs the tail of the 16-entry constant schedule.
    assign chain[0] = state_q;
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        rnd_t rnd_w;
        assign rnd_w = rnd_t'(5'd16 - nr_q + cnt_q + 5'(u));
        ascon_round u_round (
            .rnd_i         (rnd_w),
            .state_array_i (chain[u]),
            .state_array_o (chain[u+1])
        );
    end
    assign round_state_d = chain[UNROLL];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            nr_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= state_array_i;
                        nr_q    <= nr_i;
                        cnt_q   <= '0;
                        if (nr_legal) begin
                            fsm_q <= RUN;
                        end else begin
                            // Illegal round count: hand the state back untouched, flagged.
                            fsm_q       <= DONE;
                            out_valid_q <= 1'b1;
                            err_q       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    state_q <= round_state_d;
                    cnt_q   <= cnt_q + UNROLL_STEP;
                    if (cnt_q + UNROLL_STEP == nr_q) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o    = (fsm_q == IDLE);
    assign busy_o        = (fsm_q != IDLE);
    assign out_valid_o   = out_valid_q;
    assign err_o         = err_q;
    assign state_array_o = state_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// tb/tb_ascon_permutation_engine.sv - scoreboard bench driving UNROLL=1/2/4 engines in lockstep
module tb_ascon_permutation_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready, err, busy;
    logic [4:0]   nr;
    logic [319:0] st_in;
    logic [319:0] st_o [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        ascon_permutation_engine #(.UNROLL(1 << k)) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .in_valid_i    (in_valid[k]),
            .in_ready_o    (in_ready[k]),
            .nr_i          (nr),
            .state_array_i (st_in),
            .out_valid_o   (out_valid[k]),
            .out_ready_i   (out_ready[k]),
            .state_array_o (st_o[k]),
            .err_o         (err[k]),
            .busy_o        (busy[k])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // S-box from the Ascon definition, index = {x0,x1,x2,x3,x4} bit slice.
    logic [4:0] sbox_tab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int rounds);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        int          g, kk;
        for (int i = 0; i < 5; i++) x[i] = s_in[64*i +: 64];
        for (int r = 0; r < rounds; r++) begin
            g  = 16 - rounds + r;
            kk = (g + 12) % 16;
            x[2][7:0] = x[2][7:0] ^ 8'(((15 - kk) << 4) | kk);
            for (int b = 0; b < 64; b++) begin
                v = sbox_tab[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                y[0][b] = v[4];
                y[1][b] = v[3];
                y[2][b] = v[2];
                y[3][b] = v[1];
                y[4][b] = v[0];
            end
            x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
            x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
            x[2] = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
            x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
            x[4] = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    typedef struct {
        logic [319:0] st;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb_q [$];

    task automatic run_txn(input logic [4:0] nr_v, input logic [319:0] s, input bit bp);
        exp_t         e;
        int           u;
        bit           legal;
        int           lat [3];
        logic [2:0]   seen;
        logic [319:0] snap;
        for (int k = 0; k < 3; k++) begin
            u        = 1 << k;
            legal    = (nr_v >= 1) && (nr_v <= 16) && ((int'(nr_v) % u) == 0);
            e.st     = legal ? model_perm(s, int'(nr_v)) : s;
            e.err    = !legal;
            e.lat    = legal ? int'(nr_v) / u : 1;
            sb_q.push_back(e);
        end
        check($sformatf("in_ready before nr%0d", nr_v), 320'(in_ready), 320'(3'b111));
        nr       = nr_v;
        st_in    = s;
        in_valid = 3'b111;
        @(posedge clk); #1;
        in_valid = 3'b000;
        seen     = 3'b000;
        lat      = '{0, 0, 0};
        for (int c = 1; c <= 40 && seen != 3'b111; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
                if (out_valid[k] && !seen[k]) begin
                    lat[k]  = c;
                    seen[k] = 1'b1;
                end
        end
        if (bp) begin
            snap     = st_o[0];
            st_in    = ~s;
            in_valid = 3'b111;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check($sformatf("bp stable c%0d", c), st_o[0], snap);
                check($sformatf("bp in_ready c%0d", c), 320'(in_ready), 320'(3'b000));
                check($sformatf("bp out_valid c%0d", c), 320'(out_valid), 320'(3'b111));
            end
            in_valid = 3'b000;
        end
        for (int k = 0; k < 3; k++) begin
            e = sb_q.pop_front();
            check($sformatf("state u%0d nr%0d", 1 << k, nr_v), st_o[k], e.st);
            check($sformatf("err u%0d nr%0d", 1 << k, nr_v), 320'(err[k]), 320'(e.err));
            check($sformatf("lat u%0d nr%0d", 1 << k, nr_v), 320'(lat[k]), 320'(e.lat));
        end
        out_ready = 3'b111;
        @(posedge clk); #1;
        out_ready = 3'b000;
        check($sformatf("post hs valid nr%0d", nr_v), 320'({out_valid, err}), 320'(6'b0));
        check($sformatf("post hs ready nr%0d", nr_v), 320'({in_ready, busy}), 320'(6'b111000));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        nr        = 5'd0;
        st_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready/busy", 320'({in_ready, busy}), 320'(6'b111000));
        check("reset valid/err", 320'({out_valid, err}), 320'(6'b0));
        for (int k = 0; k < 3; k++) check($sformatf("reset state u%0d", 1 << k), st_o[k], 320'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(5'd12, 320'(0), 1'b0);
        run_txn(5'd8,  rand_state(), 1'b0);
        run_txn(5'd12, rand_state(), 1'b1);
        run_txn(5'd1,  320'(0), 1'b0);
        run_txn(5'd0,  rand_state(), 1'b0);
        run_txn(5'd17, rand_state(), 1'b0);
        run_txn(5'd6,  rand_state(), 1'b0);
        run_txn(5'd16, rand_state(), 1'b0);
        run_txn(5'd4,  rand_state(), 1'b0);

        // Reset pulse in the middle of a 12-round run.
        nr       = 5'd12;
        st_in    = rand_state();
        in_valid = 3'b111;
        @(posedge clk); #1;
        in_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("mid-run busy", 320'(busy), 320'(3'b111));
        rst_n = 1'b0;
        #1;
        check("rst mid-run valid", 320'(out_valid), 320'(3'b000));
        check("rst mid-run ready/busy", 320'({in_ready, busy}), 320'(6'b111000));
        check("rst mid-run state", st_o[0], 320'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(5'd2, rand_state(), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
